jcap_ctrl: RTL and testbench

Capture controller that sits between the camera pixel stream and the JPEG encoder core. It is driven by the APB register outputs (`start_capture`, `x_size_m1`, `y_size_m1`) and produces the `image_valid` / `image_size` status they read back. On each start request it gates exactly one full frame from the sensor stream into the encoder, monitors the encoder's compressed output bus, and reports the compressed byte count once the frame is done.

---
 rtl/jcap_pkg.sv | 23 ++
 rtl/jcap_ctrl_if.sv | 50 +++++
 rtl/jcap_bytecnt.sv | 44 ++++
 rtl/jcap_ctrl.sv | 137 +++++++++++++
 tb/tb_jcap_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jcap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jcap_pkg : shared types, widths and helpers for the capture block    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jcap_pkg;

    localparam int BYTES_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SOF  = 3'd1,
        ST_PASS      = 3'd2,
        ST_WAIT_JPEG = 3'd3,
        ST_DONE      = 3'd4
    } jcap_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] k);
        return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jcap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jcap_ctrl_if : register, pixel, encoder and status bundle            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface jcap_ctrl_if
    import jcap_pkg::*;
#(
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int PIX_W = 24
);
    logic               start_capture;
    logic [XW-1:0]      x_size_m1;
    logic [YW-1:0]      y_size_m1;
    logic               s_tvalid;
    logic               s_tready;
    logic [PIX_W-1:0]   s_tdata;
    logic               s_tuser;
    logic               s_tlast;
    logic               m_tvalid;
    logic               m_tready;
    logic [PIX_W-1:0]   m_tdata;
    logic               m_tuser;
    logic               m_tlast;
    logic               j_tvalid;
    logic               j_tready;
    logic               j_tlast;
    logic [3:0]         j_tkeep;
    logic               image_valid;
    logic [BYTES_W-1:0] image_size;
    logic               size_error;

    modport slave (
        input  start_capture, x_size_m1, y_size_m1,
        input  s_tvalid, s_tdata, s_tuser, s_tlast, m_tready,
        input  j_tvalid, j_tready, j_tlast, j_tkeep,
        output s_tready, m_tvalid, m_tdata, m_tuser, m_tlast,
        output image_valid, image_size, size_error
    );

    modport master (
        output start_capture, x_size_m1, y_size_m1,
        output s_tvalid, s_tdata, s_tuser, s_tlast, m_tready,
        output j_tvalid, j_tready, j_tlast, j_tkeep,
        input  s_tready, m_tvalid, m_tdata, m_tuser, m_tlast,
        input  image_valid, image_size, size_error
    );
endinterface
`default_nettype wire

// File: rtl/jcap_bytecnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jcap_bytecnt : saturating accumulator of compressed-byte enables     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jcap_bytecnt
    import jcap_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               clear_i,
    input  wire logic               en_i,
    input  wire logic [3:0]         keep_i,
    output logic      [BYTES_W-1:0] count_o
);
    localparam int SUM_W = BYTES_W + 1;

    logic [BYTES_W-1:0] count_q;
    logic [BYTES_W-1:0] count_d;
    logic [SUM_W-1:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + SUM_W'(popcount4(keep_i));
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            // carry out of the top bit means we passed the all-ones ceiling
            count_d = sum[BYTES_W] ? '1 : sum[BYTES_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/jcap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jcap_ctrl : gates one sensor frame into the encoder, sizes the output|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jcap_ctrl
    import jcap_pkg::*;
#(
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    parameter int PIX_W         = 24
)(
    input  wire logic  clk,
    input  wire logic  reset,
    jcap_ctrl_if.slave bus
);
    localparam int XW = $clog2(SENSOR_X_SIZE);
    localparam int YW = $clog2(SENSOR_Y_SIZE);

    jcap_state_t     state_q, state_d;
    logic [XW-1:0]   x_q, x_d, xm_q, xm_d;
    logic [YW-1:0]   y_q, y_d, ym_q, ym_d;
    logic            err_q, err_d;
    logic            jseen_q, jseen_d;
    logic            sready;
    logic            mvalid;
    logic [PIX_W-1:0] pix;

    logic start_ok;
    logic sof;
    logic pix_hs;
    logic x_end;
    logic y_end;
    logic j_fire;
    logic j_end;

    assign start_ok = bus.start_capture && (state_q == ST_IDLE || state_q == ST_DONE);
    assign sof      = bus.s_tvalid && bus.s_tuser;
    assign pix_hs   = bus.s_tvalid && bus.m_tready;
    assign x_end    = (x_q == xm_q);
    assign y_end    = (y_q == ym_q);
    assign j_fire   = bus.j_tvalid && bus.j_tready &&
                      (state_q == ST_PASS || state_q == ST_WAIT_JPEG);
    assign j_end    = j_fire && bus.j_tlast;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        err_d   = err_q;
        jseen_d = jseen_q || j_end;
        sready  = 1'b1;
        mvalid  = 1'b0;

        if (start_ok) begin
            xm_d    = bus.x_size_m1;
            ym_d    = bus.y_size_m1;
            x_d     = '0;
            y_d     = '0;
            err_d   = 1'b0;
            jseen_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                // hold the SOF beat upstream so it becomes the first forwarded pixel
                sready = !sof;
                if (sof) state_d = ST_PASS;
            end
            ST_PASS: begin
                mvalid = bus.s_tvalid;
                sready = bus.m_tready;
                if (pix_hs) begin
                    if (bus.s_tlast != x_end) err_d = 1'b1;
                    if (x_end) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (x_end && y_end) begin
                        state_d = (jseen_q || j_end) ? ST_DONE : ST_WAIT_JPEG;
                    end
                end
            end
            ST_WAIT_JPEG: begin
                if (j_end) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xm_q    <= '0;
            ym_q    <= '0;
            err_q   <= 1'b0;
            jseen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            err_q   <= err_d;
            jseen_q <= jseen_d;
        end
    end

    jcap_bytecnt u_bytecnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_ok),
        .en_i    (j_fire),
        .keep_i  (bus.j_tkeep),
        .count_o (bus.image_size)
    );

    assign pix             = bus.s_tdata;
    assign bus.m_tdata     = pix;
    assign bus.m_tuser     = bus.s_tuser;
    assign bus.m_tlast     = bus.s_tlast;
    assign bus.m_tvalid    = mvalid;
    assign bus.s_tready    = sready;
    assign bus.image_valid = (state_q == ST_DONE);
    assign bus.size_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jcap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jcap_ctrl : randomized bench against a frame-level reference model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jcap_ctrl;
    import jcap_pkg::*;

    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int PIX_W = 24;
    localparam int BMAX  = (1 << BYTES_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jcap_ctrl_if #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) bus ();

    jcap_ctrl #(
        .SENSOR_X_SIZE (720),
        .SENSOR_Y_SIZE (720),
        .PIX_W         (PIX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] keep;
        bit         last;
    } jbeat_t;

    int n_cmp = 0;
    int n_bad = 0;

    // capture request parameters
    int cW = 4, cH = 2;
    bit start_req = 0, rand_start = 0;
    // sensor generator: frame dims, pending dims, pixel index, frame number
    int sW = 4, sH = 2, pW = 4, pH = 2, gp = 0, fcnt = 0, sv_pct = 100;
    bit gen_on = 0, inj_err = 0;
    int mr_mode = 2;
    jbeat_t jq[$];
    // sink: pixels forwarded in the current capture
    int k = 0;
    // reference model
    int  mW = 1, mH = 1, mnpix = 0, m_bytes = 0;
    bit  m_armed = 0, m_inframe = 0, m_pixdone = 0, m_jseen = 0, m_valid = 0, m_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        return m_armed || m_inframe || (m_pixdone && !m_valid);
    endfunction

    task automatic model_reset();
        m_armed = 0; m_inframe = 0; m_pixdone = 0; m_jseen = 0; m_valid = 0; m_err = 0;
        m_bytes = 0; mnpix = 0; k = 0;
    endtask

    task automatic gen_fields();
        bus.s_tdata = {4'(fcnt), 20'(gp)};
        bus.s_tuser = (gp == 0);
        bus.s_tlast = (inj_err && gp < sW) ? (gp == 2) : ((gp % sW) == sW - 1);
        if (jq.size() > 0) begin
            bus.j_tkeep = jq[0].keep;
            bus.j_tlast = jq[0].last;
        end else begin
            bus.j_tkeep = 4'h0;
            bus.j_tlast = 1'b0;
        end
    endtask

    task automatic push_beat(input logic [3:0] kp, input bit l);
        jbeat_t b;
        b.keep = kp;
        b.last = l;
        jq.push_back(b);
    endtask

    // one clock: drive -> sample at falling edge -> model -> rising edge -> registered checks
    task automatic step();
        bit sv, su, sl, mr, jv, jr, jl, st, shs, mhs, jhs_raw;
        bit acc, counting, waitj, jhs, jend;
        bit exp_sready, exp_mvalid;
        logic [3:0] jk;
        int nb;

        bus.x_size_m1     = XW'(cW - 1);
        bus.y_size_m1     = YW'(cH - 1);
        bus.start_capture = start_req || (rand_start && model_busy() && $urandom_range(15) == 0);
        start_req = 0;
        #4;
        sv = bus.s_tvalid; su = bus.s_tuser; sl = bus.s_tlast; mr = bus.m_tready;
        jv = bus.j_tvalid; jr = bus.j_tready; jl = bus.j_tlast; jk = bus.j_tkeep;
        st = bus.start_capture;
        shs = sv && bus.s_tready;
        mhs = bus.m_tvalid && mr;
        jhs_raw = jv && jr;

        if (reset) begin
            model_reset();
        end else begin
            exp_sready = m_inframe ? mr : !(m_armed && sv && su);
            exp_mvalid = m_inframe && sv;
            check_eq("s_tready", bus.s_tready, exp_sready);
            check_eq("m_tvalid", bus.m_tvalid, exp_mvalid);
            if (bus.m_tvalid) begin
                check_eq("m_tdata", bus.m_tdata, bus.s_tdata);
                check_eq("m_tlast", bus.m_tlast, sl);
            end
            if (mhs) begin
                check_eq("pix_index", bus.m_tdata[19:0], k);
                check_eq("m_tuser", bus.m_tuser, (k == 0));
                k++;
            end

            waitj    = m_pixdone && !m_valid;
            counting = m_inframe || waitj;
            acc      = st && !m_armed && !m_inframe && !waitj;
            jhs      = counting && jhs_raw;
            jend     = jhs && jl;
            if (acc) begin
                mW = cW; mH = cH; mnpix = 0; k = 0;
                m_bytes = 0; m_err = 0; m_jseen = 0; m_valid = 0;
                m_armed = 1; m_inframe = 0; m_pixdone = 0;
            end else begin
                if (jhs) begin
                    nb = m_bytes + $countones(jk);
                    m_bytes = (nb > BMAX) ? BMAX : nb;
                end
                if (m_armed && sv && su) begin
                    m_armed = 0;
                    m_inframe = 1;
                end else if (m_inframe && sv && mr) begin
                    if (sl != ((mnpix % mW) == mW - 1)) m_err = 1;
                    if (mnpix == mW * mH - 1) begin
                        m_inframe = 0;
                        m_pixdone = 1;
                        if (m_jseen || jend) m_valid = 1;
                        check_eq("fwd_count", k, mW * mH);
                    end
                    mnpix++;
                end else if (waitj && jend) begin
                    m_valid = 1;
                end
                if (jend) m_jseen = 1;
            end
        end

        @(posedge clk);
        #1;
        check_eq("image_valid", bus.image_valid, m_valid);
        check_eq("image_size", bus.image_size, m_bytes);
        check_eq("size_error", bus.size_error, m_err);

        if (shs) begin
            gp++;
            if (gp >= sW * sH) begin
                gp = 0; fcnt++; sW = pW; sH = pH;
            end
        end
        if (!bus.s_tvalid || shs) bus.s_tvalid = gen_on && ($urandom_range(99) < sv_pct);
        case (mr_mode)
            0:       bus.m_tready = ($urandom_range(99) < 70);
            1:       bus.m_tready = !bus.m_tready;
            default: bus.m_tready = 1'b1;
        endcase
        if (jhs_raw && jq.size() > 0) void'(jq.pop_front());
        if (!bus.j_tvalid || jhs_raw) bus.j_tvalid = (jq.size() > 0) && ($urandom_range(99) < 70);
        bus.j_tready = ($urandom_range(3) != 0);
        gen_fields();
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && !m_valid; i++) step();
        check_eq("done_valid", bus.image_valid, 1);
    endtask

    task automatic wait_pass(input int limit);
        for (int i = 0; i < limit && !(m_inframe || m_pixdone); i++) step();
        check_eq("reached_pass", {31'b0, m_inframe || m_pixdone}, 1);
    endtask

    task automatic wait_pixdone(input int limit);
        for (int i = 0; i < limit && !m_pixdone; i++) step();
        check_eq("frame_forwarded", k, cW * cH);
    endtask

    task automatic capture(input int w, input int h);
        cW = w; cH = h;
        start_req = 1;
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus.start_capture = 0;
        bus.x_size_m1 = '0; bus.y_size_m1 = '0;
        bus.s_tvalid = 0; bus.m_tready = 1; bus.j_tvalid = 0; bus.j_tready = 1;
        gen_fields();
        repeat (3) step();
        reset = 1'b0;
        #1;
        check_eq("rst_s_tready", bus.s_tready, 1);
        check_eq("rst_m_tvalid", bus.m_tvalid, 0);
        check_eq("rst_image_valid", bus.image_valid, 0);
        check_eq("rst_image_size", bus.image_size, 0);
        check_eq("rst_size_error", bus.size_error, 0);

        // clean 4x2 frame, then 12 bytes in three full beats
        capture(4, 2);
        gen_on = 1;
        wait_pixdone(200);
        push_beat(4'hf, 0); push_beat(4'hf, 0); push_beat(4'hf, 1);
        wait_valid(200);
        check_eq("t1_size", bus.image_size, 12);
        check_eq("t1_pixels", k, 8);

        // start while a sensor frame is mid-flight; last beat keeps two bytes
        for (int i = 0; i < 200 && gp != 3; i++) step();
        capture(4, 2);
        wait_pass(200);
        push_beat(4'hf, 0); push_beat(4'hf, 0); push_beat(4'h3, 1);
        wait_valid(300);
        check_eq("t2_size", bus.image_size, 10);

        // m_tready toggling, plus a second start during PASS that must be ignored
        mr_mode = 1;
        capture(4, 2);
        wait_pass(200);
        start_req = 1;
        step();
        check_eq("t3_ignored_start", bus.image_valid, 0);
        push_beat(4'h7, 0); push_beat(4'hf, 1);
        wait_valid(300);
        mr_mode = 2;

        // early s_tlast on pixel 2 of the first line
        inj_err = 1;
        capture(4, 2);
        wait_pass(200);
        push_beat(4'hf, 1);
        wait_valid(300);
        check_eq("t4_size_error", bus.size_error, 1);
        inj_err = 0;

        // start from DONE clears status next cycle
        capture(4, 2);
        check_eq("t5_valid_fall", bus.image_valid, 0);
        check_eq("t5_size_clear", bus.image_size, 0);
        check_eq("t5_err_clear", bus.size_error, 0);
        wait_pass(200);
        push_beat(4'h1, 1);
        wait_valid(300);

        // randomized captures
        rand_start = 1;
        for (int f = 0; f < 30; f++) begin
            int w, h, nbeats;
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            pW = w; pH = h;
            mr_mode = $urandom_range(0, 2);
            sv_pct  = $urandom_range(50, 100);
            for (int i = 0; i < 300 && !(sW == w && sH == h); i++) step();
            capture(w, h);
            wait_pass(300);
            repeat ($urandom_range(0, 6)) step();
            nbeats = $urandom_range(1, 4);
            for (int b = 0; b < nbeats; b++) push_beat(4'($urandom), b == nbeats - 1);
            wait_valid(1000);
        end
        rand_start = 0;
        mr_mode = 2;

        // reset in the middle of a frame returns to idle
        capture(cW, cH);
        wait_pass(300);
        step();
        reset = 1'b1;
        jq.delete();
        step();
        reset = 1'b0;
        #1;
        check_eq("midrst_m_tvalid", bus.m_tvalid, 0);
        check_eq("midrst_s_tready", bus.s_tready, 1);
        check_eq("midrst_size", bus.image_size, 0);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
